multi_counter: RTL
==================

# multi_counter

Parametrised multi-channel counter/PWM generator, the successor to the single-channel 8-bit period/slope counter. It provides CHANNELS independent counters of WIDTH bits. Each channel has its own enable, period, compare threshold and count mode, with shadowed reload so that settings change glitch-free. It sits in the timing fabric and drives PWM outputs and periodic tick/wrap events to downstream logic.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- WIDTH, 8, counter/period/compare width (≥2)

- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  CHANNELS  per-channel run enable
- load  in  CHANNELS  per-channel restart strobe
- period  in  CHANNELS*WIDTH  terminal value P; channel i at [i*WIDTH +: WIDTH]
- compare  in  CHANNELS*WIDTH  PWM threshold C; same packing
- mode  in  2*CHANNELS  00 up, 01 down, 10 up-down, 11 one-shot (see Configuration); channel i at [2i +: 2]
- count  out  CHANNELS*WIDTH  current count, registered
- out  out  CHANNELS  PWM output = (count < C_shadow)
- wrap  out  CHANNELS  one-cycle pulse per completed period

## Operation
- Each channel has shadow registers P_s, C_s, M_s and a dir bit. Count arithmetic is unsigned, modulo 2^WIDTH, with no carry out.
- Shadows capture the inputs on:
  - any cycle where enable=0;
  - load=1;
  - the first enabled cycle after reset;
  - each terminal event.
- Otherwise the shadows hold. Mid-period input changes therefore take effect at the next period boundary.
- Start value S: 0 for up and up-down; P for down, using the newly captured P.
- Up:
  - count 0,1,…,P, then back to 0.
  - Terminal when count ≥ P_s; ≥ covers the case where P shrank while disabled.
  - Period is P+1 cycles.
- Down:
  - count P,…,1,0, then back to P.
  - Terminal when count == 0.
  - Period is P+1 cycles.
- Up-down:
  - dir=up: increment; at count ≥ P_s set dir=down and decrement next.
  - dir=down: decrement; at count==0, terminal, set dir=up.
  - Period is 2P cycles.
  - P=0 holds count 0 with a terminal event every cycle.
- Terminal event: count ← S, shadows reload, wrap=1 on the following cycle (registered, coincident with count == S).
- load=1 while enabled: shadows capture, count ← S, dir=up, no wrap. load has priority over terminal.
- enable=0: count and dir hold, wrap=0, out continues to track count vs C_s. Re-enabling resumes from the held count.
- out:
  - combinational from registered count and C_s;
  - C_s=0 gives constant 0;
  - C_s > P_s gives constant 1 in up and down modes.
- Mode 11 without the macro behaves exactly as up.

## Timing
- Reset (async, immediate): count=0, P_s=C_s=0, M_s=up, dir=up, wrap=0, out=0, first-cycle flag set.
- All state updates on rising clk. Inputs are sampled at the edge and need no synchronisation.
- Latency:
  - enable/load take effect at the first edge where they are sampled high;
  - new period/compare take effect at the next terminal, load, or while disabled (1-cycle capture).
- wrap is high for exactly one cycle per period and never high while enable=0.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Configuration
- COUNTER_ONESHOT_EN defined: mode 11 is one-shot up.
  - Counts 0…P; at terminal, count holds at P and wrap pulses once.
  - The channel stays halted until load=1 or enable drops and returns. Either restarts the channel from 0.
- Not defined: mode 11 decodes as free-running up. No halt logic is synthesised.

## Test plan
- CH0 up, P=9, C=3, enable from reset release → count 0..9 repeating, 10-cycle period; out high on counts 0–2; wrap 1 cycle each time count returns to 0.
- CH1 down, P=4, C=2 → count 4,3,2,1,0,4…; out high at counts 1,0; wrap coincident with count=4 after the first lap.
- CH2 up-down, P=3 → count 0,1,2,3,2,1,0,1…, 6-cycle period; wrap coincident with each return to 0 after descent.
- CH0 up, P changes 9→5 at count=4 → run continues to 9, then 0..5 repeating. Drop enable at count=3 for 7 cycles → count holds 3, no wrap. Pulse load → count=0 next cycle, no wrap.
- Assert reset asynchronously mid-count on all channels → count, out and wrap are 0 immediately, without waiting for a clk edge. After release, channels restart from S with fresh inputs.
- With COUNTER_ONESHOT_EN, mode 11, P=5 → 0..5, one wrap, count holds 5 with no further wrap; load → restarts. Without the macro, the same stimulus repeats every 6 cycles.

Source files
------------

// File: rtl/multi_counter.sv
// multi_counter: CHANNELS independent WIDTH-bit up/down/up-down PWM counters.
// Define COUNTER_ONESHOT_EN to make mode 11 a halting one-shot up counter.
module multi_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       wrap
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_UPDN = 2'b10,
    M_ONE  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] cs_q, cs_d;
    mode_e            ms_q, ms_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] p_in, c_in, s_new, step;
    mode_e            m_in;
    logic             term, step_dir, cap;
`ifdef COUNTER_ONESHOT_EN
    logic             halt_q, halt_d;
`endif

    assign p_in  = period[i*WIDTH +: WIDTH];
    assign c_in  = compare[i*WIDTH +: WIDTH];
    assign m_in  = mode_e'(mode[2*i +: 2]);
    assign s_new = (m_in == M_DOWN) ? p_in : '0;

    // Up-down is terminal on the step that lands on 0, keeping a 2P period.
    always_comb begin
      term     = 1'b0;
      step     = cnt_q + ONE;
      step_dir = 1'b0;
      unique case (ms_q)
        M_DOWN: begin
          term = (cnt_q == '0);
          step = cnt_q - ONE;
        end
        M_UPDN: begin
          if (dir_q || cnt_q >= ps_q) begin
            step     = cnt_q - ONE;
            step_dir = 1'b1;
            term     = (cnt_q <= ONE);
          end
        end
        default: term = (cnt_q >= ps_q);
      endcase
    end

    always_comb begin
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      ps_d    = ps_q;
      cs_d    = cs_q;
      ms_d    = ms_q;
      wrap_d  = 1'b0;
      first_d = first_q;
      cap     = 1'b0;
`ifdef COUNTER_ONESHOT_EN
      halt_d  = halt_q;
`endif
      if (!enable[i]) begin
        cap = 1'b1;
`ifdef COUNTER_ONESHOT_EN
        if (halt_q) begin
          halt_d  = 1'b0;
          first_d = 1'b1;
        end
`endif
      end else if (load[i] || first_q) begin
        cap     = 1'b1;
        cnt_d   = s_new;
        dir_d   = 1'b0;
        first_d = 1'b0;
`ifdef COUNTER_ONESHOT_EN
        halt_d  = 1'b0;
`endif
      end
`ifdef COUNTER_ONESHOT_EN
      else if (halt_q) begin
        cnt_d = cnt_q;
      end
`endif
      else if (term) begin
        cap    = 1'b1;
        wrap_d = 1'b1;
        cnt_d  = s_new;
        dir_d  = 1'b0;
`ifdef COUNTER_ONESHOT_EN
        if (ms_q == M_ONE) begin
          cnt_d  = cnt_q;
          halt_d = 1'b1;
        end
`endif
      end else begin
        cnt_d = step;
        dir_d = step_dir;
      end
      if (cap) begin
        ps_d = p_in;
        cs_d = c_in;
        ms_d = m_in;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        ps_q    <= '0;
        cs_q    <= '0;
        ms_q    <= M_UP;
        dir_q   <= 1'b0;
        wrap_q  <= 1'b0;
        first_q <= 1'b1;
`ifdef COUNTER_ONESHOT_EN
        halt_q  <= 1'b0;
`endif
      end else begin
        cnt_q   <= cnt_d;
        ps_q    <= ps_d;
        cs_q    <= cs_d;
        ms_q    <= ms_d;
        dir_q   <= dir_d;
        wrap_q  <= wrap_d;
        first_q <= first_d;
`ifdef COUNTER_ONESHOT_EN
        halt_q  <= halt_d;
`endif
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign out[i]                  = (cnt_q < cs_q);
    assign wrap[i]                 = wrap_q;
  end

endmodule
